// File: rtl/count_bus_monitor_pkg.sv
// Shared encodings for the counter-bus reader: FSM states, terminal counts, direction.
package count_bus_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] TC_UP = 4'hF;
    localparam logic [3:0] TC_DN = 4'h0;
    localparam logic       UP    = 1'b1;

    function automatic logic is_terminal(input logic [3:0] val, input logic dir);
        return (dir == UP) ? (val == TC_UP) : (val == TC_DN);
    endfunction

endpackage

// File: rtl/count_bus_monitor_bus_sampler.sv
// Two-flop synchronizer for the ripple counter bus plus a saturating stability
// counter; accept_qual marks a value that has been seen STABLE times in a row.
module bus_sampler #(
    parameter int unsigned STABLE = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] cnt_in,
    input  logic       cnt_en,
    input  logic       clr,
    output logic [3:0] s2_val,
    output logic       s2_en,
    output logic       accept_qual
);
    localparam logic [2:0] STAB_MAX = 3'(STABLE);

    logic [3:0] s1_val_q, s1_val_d, s2_val_q, s2_val_d;
    logic       s1_en_q, s1_en_d, s2_en_q, s2_en_d;
    logic [2:0] stab_q, stab_d;

    always_comb begin
        s1_val_d = cnt_in;
        s2_val_d = s1_val_q;
        s1_en_d  = cnt_en;
        s2_en_d  = s1_en_q;
        stab_d   = stab_q;
        // An x/z bit makes the equality unknown, which falls into the restart branch.
        if (clr)
            stab_d = 3'd0;
        else if (s1_val_q == s2_val_q) begin
            if (stab_q < STAB_MAX)
                stab_d = stab_q + 3'd1;
        end else
            stab_d = 3'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_val_q <= '0;
            s2_val_q <= '0;
            s1_en_q  <= 1'b0;
            s2_en_q  <= 1'b0;
            stab_q   <= '0;
        end else begin
            s1_val_q <= s1_val_d;
            s2_val_q <= s2_val_d;
            s1_en_q  <= s1_en_d;
            s2_en_q  <= s2_en_d;
            stab_q   <= stab_d;
        end
    end

    assign s2_val      = s2_val_q;
    assign s2_en       = s2_en_q;
    assign accept_qual = (stab_q == STAB_MAX);

endmodule

// File: rtl/count_bus_monitor.sv
// Reader for the 4-bit ripple up/down counter bus: accepts settled values,
// checks +/-1 steps, extends the count and reports terminal, wrap and errors.
//   state | meaning
//   IDLE  | nothing accepted since reset/CLR
//   TRACK | following the bus, steps are checked
//   HOLD  | counter disabled, count frozen until the next accept
module count_bus_monitor
    import count_bus_monitor_pkg::*;
#(
    parameter int unsigned W_EXT  = 8,
    parameter int unsigned STABLE = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [3:0]         CNT_IN,
    input  logic               CNT_EN,
    input  logic               UP_DOWN,
    input  logic               CLR,
    output logic [W_EXT+3:0]   EXT_CNT,
    output logic               NEW_VAL,
    output logic               WRAP,
    output logic               Z,
    output logic               ERR,
    output logic [3:0]         ERR_CNT
);
    localparam int unsigned EXT_W = W_EXT + 4;

    logic [3:0] s2_val;
    logic       s2_en, accept_qual, accept;
    logic [3:0] step;
    logic [EXT_W-1:0] resync_cnt;

    state_t           state_q, state_d;
    logic [EXT_W-1:0] ext_cnt_q, ext_cnt_d;
    logic [3:0]       last_q, last_d, err_cnt_q, err_cnt_d;
    logic             dir_q, dir_d, new_val_q, new_val_d, wrap_q, wrap_d;
    logic             z_q, z_d, err_q, err_d;

    bus_sampler #(.STABLE(STABLE)) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .cnt_in     (CNT_IN),
        .cnt_en     (CNT_EN),
        .clr        (CLR),
        .s2_val     (s2_val),
        .s2_en      (s2_en),
        .accept_qual(accept_qual)
    );

    assign accept     = accept_qual & s2_en & ((s2_val != last_q) | (state_q != TRACK));
    assign step       = s2_val - last_q;
    assign resync_cnt = (ext_cnt_q & ~EXT_W'(4'hF)) | EXT_W'(s2_val);

    always_comb begin
        state_d   = state_q;
        ext_cnt_d = ext_cnt_q;
        last_d    = last_q;
        dir_d     = dir_q;
        new_val_d = 1'b0;
        wrap_d    = 1'b0;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (CLR) begin
            state_d   = IDLE;
            ext_cnt_d = '0;
            last_d    = '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_d   = TRACK;
                    ext_cnt_d = EXT_W'(s2_val);
                end
                TRACK: if (!s2_en) begin
                    state_d = HOLD;
                end else if (accept) begin
                    // A direction flip re-bases the low nibble instead of checking the step.
                    if (UP_DOWN != dir_q)
                        ext_cnt_d = resync_cnt;
                    else if (UP_DOWN == UP && step == 4'd1) begin
                        ext_cnt_d = ext_cnt_q + EXT_W'(1);
                        wrap_d    = (s2_val == 4'd0);
                    end else if (UP_DOWN != UP && step == 4'hF) begin
                        ext_cnt_d = ext_cnt_q - EXT_W'(1);
                        wrap_d    = (s2_val == 4'hF);
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt_q == 4'hF) ? err_cnt_q : err_cnt_q + 4'd1;
                        ext_cnt_d = resync_cnt;
                    end
                end
                HOLD: if (accept) begin
                    state_d   = TRACK;
                    ext_cnt_d = resync_cnt;
                end
                default: state_d = IDLE;
            endcase
            if (accept) begin
                new_val_d = 1'b1;
                last_d    = s2_val;
                dir_d     = UP_DOWN;
            end
        end
        z_d = (state_d == TRACK) && is_terminal(last_d, UP_DOWN);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            ext_cnt_q <= '0;
            last_q    <= '0;
            dir_q     <= 1'b0;
            new_val_q <= 1'b0;
            wrap_q    <= 1'b0;
            z_q       <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ext_cnt_q <= ext_cnt_d;
            last_q    <= last_d;
            dir_q     <= dir_d;
            new_val_q <= new_val_d;
            wrap_q    <= wrap_d;
            z_q       <= z_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign EXT_CNT = ext_cnt_q;
    assign NEW_VAL = new_val_q;
    assign WRAP    = wrap_q;
    assign Z       = z_q;
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_count_bus_monitor.sv
// Directed bench for count_bus_monitor: counting, direction change, glitches,
// step errors, disable/hold, CLR priority, underflow and async reset.
module tb_count_bus_monitor;
    logic        CLK, RST, CNT_EN, UP_DOWN, CLR;
    logic [3:0]  CNT_IN;
    logic [11:0] EXT_CNT;
    logic        NEW_VAL, WRAP, Z, ERR;
    logic [3:0]  ERR_CNT;

    int tests, failed, nv_cnt, wrap_cnt;

    count_bus_monitor #(.W_EXT(8), .STABLE(2)) dut (
        .CLK(CLK), .RST(RST), .CNT_IN(CNT_IN), .CNT_EN(CNT_EN), .UP_DOWN(UP_DOWN),
        .CLR(CLR), .EXT_CNT(EXT_CNT), .NEW_VAL(NEW_VAL), .WRAP(WRAP), .Z(Z),
        .ERR(ERR), .ERR_CNT(ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (NEW_VAL === 1'b1) nv_cnt++;
        if (WRAP === 1'b1) wrap_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic hold_val(input logic [3:0] v, input int n);
        CNT_IN = v;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        RST = 1'b0; CLR = 1'b0; CNT_EN = 1'b1; UP_DOWN = 1'b1; CNT_IN = 4'd0;
        #2;
        tests++;
        if ({EXT_CNT, NEW_VAL, WRAP, Z, ERR, ERR_CNT} !== 20'd0) begin
            failed++;
            $display("FAIL reset_outputs: got ext=%h nv=%b wr=%b z=%b err=%b ec=%h, want all 0",
                     EXT_CNT, NEW_VAL, WRAP, Z, ERR, ERR_CNT);
        end
        repeat (3) tick();
        RST = 1'b1;
    endtask

    task automatic test_count_up();
        nv_cnt = 0; wrap_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            hold_val(4'(i % 16), 10);
            if (i == 15) begin
                tests++;
                if (Z !== 1'b1) begin failed++; $display("FAIL up_z_at_15: got %b want 1", Z); end
            end
            if (i == 14) begin
                tests++;
                if (Z !== 1'b0) begin failed++; $display("FAIL up_z_at_14: got %b want 0", Z); end
            end
        end
        tests++;
        if (nv_cnt !== 20) begin failed++; $display("FAIL up_new_val_count: got %0d want 20", nv_cnt); end
        tests++;
        if (wrap_cnt !== 1) begin failed++; $display("FAIL up_wrap_count: got %0d want 1", wrap_cnt); end
        tests++;
        if (EXT_CNT !== 12'h013) begin failed++; $display("FAIL up_ext_cnt: got %h want 013", EXT_CNT); end
        tests++;
        if (ERR !== 1'b0) begin failed++; $display("FAIL up_err: got %b want 0", ERR); end
    endtask

    task automatic test_count_down();
        UP_DOWN = 1'b0;
        nv_cnt = 0; wrap_cnt = 0;
        hold_val(4'd12, 10);
        tests++;
        if (EXT_CNT !== 12'h01C) begin failed++; $display("FAIL dn_resync_ext: got %h want 01C", EXT_CNT); end
        tests++;
        if (ERR !== 1'b0 || nv_cnt !== 1) begin
            failed++; $display("FAIL dn_resync: got err=%b nv=%0d want err=0 nv=1", ERR, nv_cnt);
        end
        for (int v = 11; v >= 0; v--) hold_val(4'(v), 10);
        tests++;
        if (Z !== 1'b1) begin failed++; $display("FAIL dn_z_at_0: got %b want 1", Z); end
        tests++;
        if (EXT_CNT !== 12'h010) begin failed++; $display("FAIL dn_ext_at_0: got %h want 010", EXT_CNT); end
        hold_val(4'd15, 10);
        tests++;
        if (EXT_CNT !== 12'h00F) begin failed++; $display("FAIL dn_ext_wrap: got %h want 00F", EXT_CNT); end
        tests++;
        if (wrap_cnt !== 1 || nv_cnt !== 14) begin
            failed++; $display("FAIL dn_pulses: got wrap=%0d nv=%0d want wrap=1 nv=14", wrap_cnt, nv_cnt);
        end
        tests++;
        if (ERR !== 1'b0 || Z !== 1'b0) begin failed++; $display("FAIL dn_err_z: got err=%b z=%b want 0 0", ERR, Z); end
    endtask

    task automatic test_glitch();
        UP_DOWN = 1'b1;
        hold_val(4'd7, 10);
        tests++;
        if (EXT_CNT !== 12'h007) begin failed++; $display("FAIL gl_base: got %h want 007", EXT_CNT); end
        nv_cnt = 0;
        hold_val(4'd6, 1);
        hold_val(4'd4, 1);
        hold_val(4'd8, 10);
        tests++;
        if (nv_cnt !== 1) begin failed++; $display("FAIL gl_accepts: got %0d want 1", nv_cnt); end
        tests++;
        if (EXT_CNT !== 12'h008 || ERR !== 1'b0) begin
            failed++; $display("FAIL gl_result: got ext=%h err=%b want 008 0", EXT_CNT, ERR);
        end
    endtask

    task automatic test_illegal_step();
        for (int i = 9; i < 22; i++) hold_val(4'(i % 16), 10);
        tests++;
        if (EXT_CNT !== 12'h015 || ERR !== 1'b0) begin
            failed++; $display("FAIL il_pre: got ext=%h err=%b want 015 0", EXT_CNT, ERR);
        end
        hold_val(4'd9, 10);
        tests++;
        if (ERR !== 1'b1 || ERR_CNT !== 4'd1) begin
            failed++; $display("FAIL il_err: got err=%b ec=%0d want 1 1", ERR, ERR_CNT);
        end
        tests++;
        if (EXT_CNT !== 12'h019) begin failed++; $display("FAIL il_ext: got %h want 019", EXT_CNT); end
        hold_val(4'd10, 10);
        tests++;
        if (EXT_CNT !== 12'h01A || ERR_CNT !== 4'd1) begin
            failed++; $display("FAIL il_next: got ext=%h ec=%0d want 01A 1", EXT_CNT, ERR_CNT);
        end
    endtask

    task automatic test_hold();
        for (int v = 11; v <= 15; v++) hold_val(4'(v), 10);
        tests++;
        if (Z !== 1'b1 || EXT_CNT !== 12'h01F) begin
            failed++; $display("FAIL hd_pre: got z=%b ext=%h want 1 01F", Z, EXT_CNT);
        end
        nv_cnt = 0; wrap_cnt = 0;
        CNT_EN = 1'b0;
        CNT_IN = 4'bzzzz;
        repeat (20) tick();
        tests++;
        if (nv_cnt !== 0 || wrap_cnt !== 0) begin
            failed++; $display("FAIL hd_pulses: got nv=%0d wrap=%0d want 0 0", nv_cnt, wrap_cnt);
        end
        tests++;
        if (Z !== 1'b0 || EXT_CNT !== 12'h01F) begin
            failed++; $display("FAIL hd_state: got z=%b ext=%h want 0 01F", Z, EXT_CNT);
        end
        CNT_EN = 1'b1;
        hold_val(4'd2, 10);
        tests++;
        if (nv_cnt !== 1 || EXT_CNT !== 12'h012) begin
            failed++; $display("FAIL hd_return: got nv=%0d ext=%h want 1 012", nv_cnt, EXT_CNT);
        end
        tests++;
        if (ERR !== 1'b1 || ERR_CNT !== 4'd1) begin
            failed++; $display("FAIL hd_err_kept: got err=%b ec=%0d want 1 1", ERR, ERR_CNT);
        end
    endtask

    task automatic test_clr();
        CNT_IN = 4'd3;
        repeat (3) tick();
        CLR = 1'b1;
        tick();
        tests++;
        if (EXT_CNT !== 12'h000 || NEW_VAL !== 1'b0) begin
            failed++; $display("FAIL clr_priority: got ext=%h nv=%b want 000 0", EXT_CNT, NEW_VAL);
        end
        tests++;
        if (ERR !== 1'b1 || ERR_CNT !== 4'd1 || Z !== 1'b0) begin
            failed++; $display("FAIL clr_kept: got err=%b ec=%0d z=%b want 1 1 0", ERR, ERR_CNT, Z);
        end
        CLR = 1'b0;
        nv_cnt = 0;
        repeat (10) tick();
        tests++;
        if (nv_cnt !== 1 || EXT_CNT !== 12'h003) begin
            failed++; $display("FAIL clr_reaccept: got nv=%0d ext=%h want 1 003", nv_cnt, EXT_CNT);
        end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        UP_DOWN = 1'b0;
        hold_val(4'd0, 10);
        tests++;
        if (EXT_CNT !== 12'h000 || Z !== 1'b1) begin
            failed++; $display("FAIL uf_base: got ext=%h z=%b want 000 1", EXT_CNT, Z);
        end
        wrap_cnt = 0;
        hold_val(4'd15, 10);
        tests++;
        if (EXT_CNT !== 12'hFFF || wrap_cnt !== 1) begin
            failed++; $display("FAIL uf_wrap: got ext=%h wrap=%0d want FFF 1", EXT_CNT, wrap_cnt);
        end
        tests++;
        if (ERR_CNT !== 4'd1) begin failed++; $display("FAIL uf_err_cnt: got %0d want 1", ERR_CNT); end
    endtask

    task automatic test_async_reset();
        CNT_IN = 4'd14;
        repeat (2) tick();
        #3;
        RST = 1'b0;
        #1;
        tests++;
        if ({EXT_CNT, NEW_VAL, WRAP, Z, ERR, ERR_CNT} !== 20'd0) begin
            failed++;
            $display("FAIL async_reset: got ext=%h nv=%b wr=%b z=%b err=%b ec=%h, want all 0",
                     EXT_CNT, NEW_VAL, WRAP, Z, ERR, ERR_CNT);
        end
        #1;
        RST = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        tests = 0; failed = 0; nv_cnt = 0; wrap_cnt = 0;
        test_reset();
        test_count_up();
        test_count_down();
        test_glitch();
        test_illegal_step();
        test_hold();
        test_clr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
